// File: rtl/nfc_acg_pkg.sv
// Shared types and constants for the NAND command/address issuer.
package nfc_acg_pkg;

  typedef enum logic [2:0] {
    sIdle, sSetup, sWeLow, sWeHigh, sRelease, sWaitTWB, sWaitRdy, sDone
  } issuerState_t;

  localparam logic [2:0] MaxAddrBytes = 3'd5;

  // Pin levels while idle; these are also the reset levels.
  localparam logic       IdleWE   = 1'b1;
  localparam logic       IdleRE   = 1'b1;
  localparam logic       IdleALE  = 1'b0;
  localparam logic       IdleCLE  = 1'b0;
  localparam logic       IdleDQOE = 1'b0;
  localparam logic [7:0] IdleDQ   = 8'h00;

  function automatic logic [2:0] clampAddrCount(input logic [2:0] n);
    return (n > MaxAddrBytes) ? MaxAddrBytes : n;
  endfunction

endpackage

// File: rtl/nfc_acg_byte_strobe.sv
// Per-byte WE timer: WELowCycles low followed by WEHighCycles high after each load.
module nfc_acg_byte_strobe #(
  parameter int WELowCycles  = 2,
  parameter int WEHighCycles = 2
) (
  input  logic iSystemClock,
  input  logic iModuleReset,
  input  logic iLoad,
  output logic oBusy,
  output logic oLowLast,
  output logic oLast
);
  localparam int Total = WELowCycles + WEHighCycles;
  localparam int CntW  = $clog2(Total + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(Total - 1);
  localparam logic [CntW-1:0] CntHigh = CntW'(WEHighCycles);

  logic [CntW-1:0] cnt;
  logic            busy;

  // Counts down through the byte; a load on the final cycle chains the next byte seamlessly.
  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (iLoad) begin
      busy <= 1'b1;
      cnt  <= CntLoad;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  assign oBusy    = busy;
  assign oLowLast = busy && (cnt == CntHigh);
  assign oLast    = busy && (cnt == '0);

endmodule

// File: rtl/nfc_acg_cmd_addr_issuer.sv
// Atomic command/address issuer: drives one opcode plus up to five address bytes to the PHY,
// optionally waiting for the selected way's R/B to return high.
module nfc_acg_cmd_addr_issuer
  import nfc_acg_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int WELowCycles  = 2,
  parameter int WEHighCycles = 2,
  parameter int TWBCycles    = 10
) (
  input  logic                        iSystemClock,
  input  logic                        iModuleReset,
  input  logic                        iStart,
  output logic                        oReady,
  input  logic [NumberOfWays-1:0]     iTargetID,
  input  logic [7:0]                  iOpcode,
  input  logic [2:0]                  iAddrCount,
  input  logic [39:0]                 iAddress,
  input  logic                        iWaitRB,
  output logic                        oDone,
  input  logic [NumberOfWays-1:0]     iReadyBusy,
  output logic                        oACG_PHY_DQOutEnable,
  output logic                        oACG_PHY_DQSOutEnable,
  output logic [31:0]                 oACG_PHY_DQ,
  output logic [7:0]                  oACG_PHY_DQStrobe,
  output logic [2*NumberOfWays-1:0]   oACG_PHY_ChipEnable,
  output logic [3:0]                  oACG_PHY_WriteEnable,
  output logic [3:0]                  oACG_PHY_ReadEnable,
  output logic [3:0]                  oACG_PHY_AddressLatchEnable,
  output logic [3:0]                  oACG_PHY_CommandLatchEnable
);
  localparam int TwbW = $clog2(TWBCycles + 1);
  localparam logic [TwbW-1:0] TwbLoad = TwbW'(TWBCycles - 1);

  issuerState_t              state;
  logic [NumberOfWays-1:0]   target;
  logic [39:0]               addrShift;
  logic [2:0]                bytesLeft;
  logic                      waitRB;
  logic [TwbW-1:0]           twbCnt;
  logic [NumberOfWays-1:0]   ceReg;
  logic                      weReg, cleReg, aleReg, dqOeReg, doneReg, readyReg;
  logic [7:0]                dqReg;

  logic strobeLoad, strobeBusy, strobeLowLast, strobeLast, byteEnd;

  // An idle timer inside WE_HIGH is treated as end-of-byte so the FSM can never stall there.
  assign byteEnd    = strobeLast || !strobeBusy;
  assign strobeLoad = (state == sSetup) ||
                      ((state == sWeHigh) && byteEnd && (bytesLeft != 3'd0));

  nfc_acg_byte_strobe #(
    .WELowCycles (WELowCycles),
    .WEHighCycles(WEHighCycles)
  ) uStrobe (
    .iSystemClock(iSystemClock),
    .iModuleReset(iModuleReset),
    .iLoad       (strobeLoad),
    .oBusy       (strobeBusy),
    .oLowLast    (strobeLowLast),
    .oLast       (strobeLast)
  );

  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      state     <= sIdle;
      target    <= '0;
      addrShift <= '0;
      bytesLeft <= '0;
      waitRB    <= 1'b0;
      twbCnt    <= '0;
      ceReg     <= '1;
      weReg     <= IdleWE;
      cleReg    <= IdleCLE;
      aleReg    <= IdleALE;
      dqReg     <= IdleDQ;
      dqOeReg   <= IdleDQOE;
      doneReg   <= 1'b0;
      readyReg  <= 1'b1;
    end else begin
      case (state)
        sIdle: if (iStart) begin
          state     <= sSetup;
          target    <= iTargetID;
          addrShift <= iAddress;
          bytesLeft <= clampAddrCount(iAddrCount);
          waitRB    <= iWaitRB;
          ceReg     <= ~iTargetID;
          cleReg    <= 1'b1;
          dqReg     <= iOpcode;
          dqOeReg   <= 1'b1;
          readyReg  <= 1'b0;
        end
        sSetup: begin
          state <= sWeLow;
          weReg <= 1'b0;
        end
        sWeLow: if (strobeLowLast) begin
          state <= sWeHigh;
          weReg <= 1'b1;
        end
        sWeHigh: if (byteEnd) begin
          if (bytesLeft != 3'd0) begin
            state     <= sWeLow;
            weReg     <= 1'b0;
            cleReg    <= 1'b0;
            aleReg    <= 1'b1;
            dqReg     <= addrShift[7:0];
            addrShift <= {8'h00, addrShift[39:8]};
            bytesLeft <= bytesLeft - 3'd1;
          end else begin
            state   <= sRelease;
            cleReg  <= IdleCLE;
            aleReg  <= IdleALE;
            dqReg   <= IdleDQ;
            dqOeReg <= IdleDQOE;
          end
        end
        sRelease: if (waitRB) begin
          state  <= sWaitTWB;
          twbCnt <= TwbLoad;
        end else begin
          state   <= sDone;
          ceReg   <= '1;
          doneReg <= 1'b1;
        end
        sWaitTWB: begin
          if (twbCnt == '0) state  <= sWaitRdy;
          else              twbCnt <= twbCnt - 1'b1;
        end
        sWaitRdy: if ((iReadyBusy & target) != '0) begin
          state   <= sDone;
          ceReg   <= '1;
          doneReg <= 1'b1;
        end
        sDone: begin
          state    <= sIdle;
          doneReg  <= 1'b0;
          readyReg <= 1'b1;
        end
        default: state <= sIdle;
      endcase
    end
  end

  assign oReady                      = readyReg;
  assign oDone                       = doneReg;
  assign oACG_PHY_DQOutEnable        = dqOeReg;
  assign oACG_PHY_DQSOutEnable       = 1'b0;
  assign oACG_PHY_DQ                 = {4{dqReg}};
  assign oACG_PHY_DQStrobe           = 8'h00;
  assign oACG_PHY_ChipEnable         = {2{ceReg}};
  assign oACG_PHY_WriteEnable        = {4{weReg}};
  assign oACG_PHY_ReadEnable         = {4{IdleRE}};
  assign oACG_PHY_AddressLatchEnable = {4{aleReg}};
  assign oACG_PHY_CommandLatchEnable = {4{cleReg}};

endmodule
